// File: rtl/modexp_3023_pkg.sv
// Shared constants and helpers for the GF(3023) modular exponentiation engine.
// The state encodings are plain constants so that legacy tools can consume them.
package modexp_3023_pkg;

    localparam int Q      = 3023;
    localparam int MU     = 5549;
    localparam int SHIFT  = 12;
    localparam int RES_W  = 12;
    localparam int PROD_W = 24;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t LOAD = 3'd1;
    localparam state_t SQR  = 3'd2;
    localparam state_t MUL  = 3'd3;
    localparam state_t DONE = 3'd4;

    // A 12-bit base is always below 2*Q, so one subtraction makes it canonical.
    function automatic logic [RES_W-1:0] reduce_once(input logic [RES_W-1:0] v);
        return (v >= RES_W'(Q)) ? v - RES_W'(Q) : v;
    endfunction

endpackage

// File: rtl/barrett_reduce24_3023.sv
// Combinational Barrett reduction of a 24-bit product to a canonical residue mod 3023.
// The quotient estimate undershoots by at most three, so three corrective subtractions follow.
module barrett_reduce24_3023
    import modexp_3023_pkg::*;
(
    input  logic [PROD_W-1:0] x,
    output logic [RES_W-1:0]  r
);

    logic [12:0]       t;
    logic [PROD_W-1:0] tq;
    logic [13:0]       r0;
    logic [13:0]       r1;
    logic [13:0]       r2;
    logic [13:0]       r3;

    always_comb begin
        t  = 13'((25'(x[PROD_W-1:SHIFT]) * 25'(MU)) >> SHIFT);
        tq = 24'(t) * 24'(Q);
        r0 = 14'(x - tq);
        r1 = (r0 >= 14'(Q)) ? r0 - 14'(Q) : r0;
        r2 = (r1 >= 14'(Q)) ? r1 - 14'(Q) : r1;
        r3 = (r2 >= 14'(Q)) ? r2 - 14'(Q) : r2;
    end

    assign r = RES_W'(r3);

endmodule

// File: rtl/modexp_3023.sv
// Constant-time MSB-first square-and-multiply computing base^exp mod 3023.
// One shared multiplier and Barrett reducer serve both the square and the multiply step.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// LOAD  | acc <- 1, idx <- EXP_W-1
// SQR   | acc <- acc*acc mod Q
// MUL   | acc <- acc*base mod Q when exp[idx] is set; cycle spent regardless
// DONE  | one-cycle done pulse, result valid
module modexp_3023
    import modexp_3023_pkg::*;
#(
    parameter int EXP_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RES_W-1:0] base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result
);

    localparam int IDX_W = $clog2(EXP_W);

    state_t            state;
    logic [EXP_W-1:0]  exp_r;
    logic [RES_W-1:0]  base_r;
    logic [RES_W-1:0]  acc;
    logic [RES_W-1:0]  result_r;
    logic [IDX_W-1:0]  idx;
    logic [RES_W-1:0]  opnd;
    logic [PROD_W-1:0] prod;
    logic [RES_W-1:0]  red;

    assign opnd = (state == SQR) ? acc : base_r;
    assign prod = PROD_W'(acc) * PROD_W'(opnd);

    barrett_reduce24_3023 u_reduce (
        .x (prod),
        .r (red)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            exp_r    <= '0;
            base_r   <= '0;
            acc      <= RES_W'(1);
            idx      <= '0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_r  <= exp;
                        base_r <= reduce_once(base);
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= RES_W'(1);
                    idx   <= IDX_W'(EXP_W - 1);
                    state <= SQR;
                end
                SQR: begin
                    acc   <= red;
                    state <= MUL;
                end
                MUL: begin
                    if (exp_r[idx]) begin
                        acc <= red;
                    end
                    // Capture the final value on the last step so result is valid during DONE.
                    if (idx == '0) begin
                        result_r <= exp_r[idx] ? red : acc;
                        state    <= DONE;
                    end else begin
                        idx   <= idx - IDX_W'(1);
                        state <= SQR;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = result_r;

endmodule
